wb_retire_queue: RTL and testbench
==================================

WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, pending-entry capacity (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, register/data width (32 only legal value for RV32 builds, checked by elaboration assertion).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  upstream entry valid.
REQ-006 in_ready  out  1  queue can accept (= !full).
REQ-007 in_rd  in  5  destination register.
REQ-008 in_sel  in  4  regfilemux select (package enum: alu_out, br_en, u_imm, pc_plus4, lw, lb, lbu, lh, lhu).
REQ-009 in_result  in  XLEN  precomputed value for non-load selects.
REQ-010 in_offset  in  2  load byte offset (address[1:0]).
REQ-011 dmem_resp_valid  in  1  load data returned, in order.
REQ-012 dmem_rdata  in  XLEN  load data word.
REQ-013 rf_we  out  1  regfile write strobe.
REQ-014 rf_rd  out  5  regfile write index.
REQ-015 rf_wdata  out  XLEN  regfile write data.
REQ-016 count  out  $clog2(DEPTH)+1  occupied entries.
REQ-017 resp_err  out  1  sticky: unexpected dmem response.

Function
REQ-018 SHALL push {rd, sel, result, offset} into circular FIFO when in_valid && in_ready; wrap pointers modulo DEPTH.
REQ-019 in_ready SHALL be combinational !full; no push when full even if a retire occurs same cycle.
REQ-020 Head SHALL retire when non-load, or when load and dmem_resp_valid same cycle; at most one retire per cycle, strictly in order.
REQ-021 Push and retire in the same cycle SHALL leave count unchanged; push into empty queue SHALL NOT retire in that cycle.
REQ-022 Retire SHALL register outputs: rf_we/rf_rd/rf_wdata valid the cycle after the retire edge, rf_we high exactly one cycle per retire.
REQ-023 Retire with rd==0 SHALL pop but hold rf_we low.
REQ-024 Load extraction: lw = dmem_rdata; lb/lbu = byte at offset*8, sign/zero-extended; lh/lhu = halfword at offset*8, sign/zero-extended.
REQ-025 dmem_resp_valid with empty queue or non-load head SHALL be dropped and set resp_err until reset.
REQ-026 Non-load head SHALL retire even if dmem_resp_valid is asserted; the response is then handled per REQ-025.
REQ-027 Minimum latency non-load: accept edge N, rf_we high in cycle N+2.

Reset
REQ-028 rst_n low SHALL immediately clear pointers, count=0, rf_we=0, rf_rd=0, rf_wdata=0, resp_err=0; in-flight entries discarded mid-operation.

Configuration
REQ-029 With WB_MISALIGN_CHECK_EN defined: lh/lhu at offset 3 or lw at offset !=0 SHALL retire with rf_we=0 and pulse output misalign_err (1 bit, registered, aligned with rf_we slot); port absent otherwise.
REQ-030 Without WB_MISALIGN_CHECK_EN: lh/lhu at offset 3 SHALL use byte 3 as low byte, 0 as high byte before extension; lw ignores offset.

Structure
REQ-031 regfilemux select enum and wb entry struct SHALL live in rv32i_types package.
REQ-032 Load extraction SHALL be a combinational sub-module load_extract (sel, offset, rdata -> value).

Verification
REQ-033 Reset, push alu_out rd=5 result=0x1234 -> cycle N+2 rf_we=1, rf_rd=5, rf_wdata=0x1234.
REQ-034 Push lb rd=3 offset=2; resp rdata=0x00800000 -> rf_wdata=0xFFFFFF80; lbu same -> 0x00000080.
REQ-035 Push DEPTH loads, no resp -> in_ready=0, count=DEPTH; one resp plus in_valid same cycle -> no push, count=DEPTH-1.
REQ-036 dmem_resp_valid with empty queue -> resp_err=1, no rf_we, stays 1 until rst_n low.
REQ-037 Push rd=0 alu_out then rd=7 lhu offset=3, resp 0xAB000000 -> first no rf_we; second rf_wdata=0x000000AB (macro off) / rf_we=0, misalign_err=1 (macro on).
REQ-038 Assert rst_n low with 3 entries pending -> count=0, rf_we=0 asynchronously; later resp sets resp_err.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I writeback types: regfile mux select encoding and the
// retire-queue entry record, plus small decode helpers.
package rv32i_types;

  localparam int unsigned RV_XLEN = 32;

  typedef enum logic [3:0] {
    alu_out  = 4'd0,
    br_en    = 4'd1,
    u_imm    = 4'd2,
    pc_plus4 = 4'd3,
    lw       = 4'd4,
    lb       = 4'd5,
    lbu      = 4'd6,
    lh       = 4'd7,
    lhu      = 4'd8
  } regfilemux_sel_t;

  typedef struct packed {
    logic [4:0]         rd;
    regfilemux_sel_t    sel;
    logic [RV_XLEN-1:0] result;
    logic [1:0]         offset;
  } wb_entry_t;

  function automatic logic is_load(regfilemux_sel_t sel);
    return (sel == lw) || (sel == lb) || (sel == lbu) || (sel == lh) || (sel == lhu);
  endfunction

  // Halfword straddling the word boundary, or any unaligned word.
  function automatic logic is_misaligned(regfilemux_sel_t sel, logic [1:0] offset);
    return (((sel == lh) || (sel == lhu)) && (offset == 2'd3)) ||
           ((sel == lw) && (offset != 2'd0));
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load data extraction: selects byte/halfword at the byte
// offset and sign- or zero-extends. A halfword at offset 3 sees zero as its
// high byte because the shifted-in bits are zero.
module load_extract
  import rv32i_types::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  regfilemux_sel_t  sel_i,
  input  logic [1:0]       offset_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [XLEN-1:0]  value_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  // Extend the selected lane according to the load flavour.
  always_comb begin
    value_o = '0;
    case (sel_i)
      lw:      value_o = rdata_i;
      lb:      value_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      lbu:     value_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      lh:      value_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      lhu:     value_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: value_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_retire_queue.sv
// In-order writeback retire queue. Entries carry either a precomputed result
// or a pending load; loads retire only when the in-order dmem response
// arrives. Regfile write port is registered (one cycle after retire).
// Optional feature: define WB_MISALIGN_CHECK_EN to suppress writes of
// misaligned lh/lhu/lw and pulse misalign_err instead.
module wb_retire_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [3:0]               in_sel,
  input  logic [XLEN-1:0]          in_result,
  input  logic [1:0]               in_offset,
  input  logic                     dmem_resp_valid,
  input  logic [XLEN-1:0]          dmem_rdata,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [XLEN-1:0]          rf_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     resp_err
`ifdef WB_MISALIGN_CHECK_EN
  ,
  output logic                     misalign_err
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  if (XLEN != RV_XLEN) begin : g_xlen_chk
    $error("wb_retire_queue: XLEN must be 32 for RV32 builds");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("wb_retire_queue: DEPTH must be a power of two >= 2");
  end

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            rf_we_q, resp_err_q;
  logic [4:0]      rf_rd_q;
  logic [XLEN-1:0] rf_wdata_q;

  wb_entry_t       head, in_entry;
  logic            full, empty, push, retire, head_load, head_misalign, resp_drop;
  logic [XLEN-1:0] load_val, ret_data;

  assign head      = mem_q[rd_ptr_q];
  assign head_load = is_load(head.sel);
  assign full      = (count_q == (PtrW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  // An empty queue never retires, so a push into empty waits one cycle.
  assign retire    = !empty && (!head_load || dmem_resp_valid);
  assign resp_drop = dmem_resp_valid && (empty || !head_load);

`ifdef WB_MISALIGN_CHECK_EN
  assign head_misalign = is_misaligned(head.sel, head.offset);
`else
  assign head_misalign = 1'b0;
`endif

  assign in_entry.rd     = in_rd;
  assign in_entry.sel    = regfilemux_sel_t'(in_sel);
  assign in_entry.result = in_result;
  assign in_entry.offset = in_offset;

  load_extract #(
    .XLEN (XLEN)
  ) u_load_extract (
    .sel_i    (head.sel),
    .offset_i (head.offset),
    .rdata_i  (dmem_rdata),
    .value_o  (load_val)
  );

  assign ret_data = head_load ? load_val : head.result;

  // Occupancy next state: simultaneous push and retire cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entry storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (retire) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Registered regfile write port and sticky response error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      rf_we_q <= retire && (head.rd != 5'd0) && !head_misalign;
      if (retire) begin
        rf_rd_q    <= head.rd;
        rf_wdata_q <= ret_data;
      end
      if (resp_drop) resp_err_q <= 1'b1;
    end
  end

`ifdef WB_MISALIGN_CHECK_EN
  logic misalign_q;

  // Misalign pulse occupies the same slot the suppressed write would have.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= retire && head_misalign;
  end

  assign misalign_err = misalign_q;
`endif

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign count    = count_q;
  assign resp_err = resp_err_q;

endmodule

// File: tb/tb_wb_retire_queue.sv
// Self-checking bench for wb_retire_queue: directed vector table, hand-written
// corner sequences (full queue, stray responses, async reset) and random
// traffic checked against a queue-based reference model.
module tb_wb_retire_queue;
  import rv32i_types::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd;
  logic [3:0]  in_sel;
  logic [31:0] in_result;
  logic [1:0]  in_offset;
  logic        dmem_resp_valid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [2:0]  count;
  logic        resp_err;
`ifdef WB_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  wb_retire_queue #(
    .DEPTH (DEPTH),
    .XLEN  (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rd           (in_rd),
    .in_sel          (in_sel),
    .in_result       (in_result),
    .in_offset       (in_offset),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_rdata      (dmem_rdata),
    .rf_we           (rf_we),
    .rf_rd           (rf_rd),
    .rf_wdata        (rf_wdata),
    .count           (count),
    .resp_err        (resp_err)
`ifdef WB_MISALIGN_CHECK_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]      rd;
    regfilemux_sel_t sel;
    logic [31:0]     res;
    logic [1:0]      off;
  } ment_t;

  ment_t       mq[$];
  logic        m_err, m_we, m_mis;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  function automatic bit m_is_load(regfilemux_sel_t s);
    return s == lw || s == lb || s == lbu || s == lh || s == lhu;
  endfunction

  function automatic bit m_misaligned(regfilemux_sel_t s, logic [1:0] off);
`ifdef WB_MISALIGN_CHECK_EN
    return ((s == lh || s == lhu) && off == 2'd3) || (s == lw && off != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_extract(regfilemux_sel_t s, logic [1:0] off,
                                            logic [31:0] rdata);
    logic [31:0] sh, v;
    sh = rdata >> (8 * off);
    case (s)
      lb:      begin v = sh & 32'hFF;   return (v >= 32'd128)   ? v - 32'd256   : v; end
      lbu:     return sh & 32'hFF;
      lh:      begin v = sh & 32'hFFFF; return (v >= 32'd32768) ? v - 32'd65536 : v; end
      lhu:     return sh & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_err = 1'b0;
    m_we  = 1'b0;
    m_mis = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [4:0] rd, input regfilemux_sel_t s,
                            input logic [31:0] res, input logic [1:0] off, input logic resp,
                            input logic [31:0] rdata);
    int    sz;
    bit    head_load;
    ment_t h, e;
    sz    = mq.size();
    m_we  = 1'b0;
    m_mis = 1'b0;
    head_load = (sz > 0) ? m_is_load(mq[0].sel) : 1'b0;
    if (resp && (sz == 0 || !head_load)) m_err = 1'b1;
    if (sz > 0 && (!head_load || resp)) begin
      h     = mq.pop_front();
      m_mis = m_misaligned(h.sel, h.off);
      m_we  = (h.rd != 5'd0) && !m_mis;
      m_rd  = h.rd;
      m_wd  = head_load ? m_extract(h.sel, h.off, rdata) : h.res;
    end
    if (v && sz < DEPTH) begin
      e.rd = rd; e.sel = s; e.res = res; e.off = off;
      mq.push_back(e);
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge.
  task automatic cycle(input logic v, input logic [4:0] rd, input regfilemux_sel_t s,
                       input logic [31:0] res, input logic [1:0] off, input logic resp,
                       input logic [31:0] rdata);
    in_valid = v; in_rd = rd; in_sel = s; in_result = res; in_offset = off;
    dmem_resp_valid = resp; dmem_rdata = rdata;
    model_step(v, rd, s, res, off, resp, rdata);
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("resp_err", 32'(resp_err), 32'(m_err));
    if (m_we) begin
      chk("rf_rd", 32'(rf_rd), 32'(m_rd));
      chk("rf_wdata", rf_wdata, m_wd);
    end
`ifdef WB_MISALIGN_CHECK_EN
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
`endif
    in_valid = 1'b0;
    dmem_resp_valid = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, alu_out, 32'd0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; dmem_resp_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            v;
    logic [4:0]      rd;
    regfilemux_sel_t sel;
    logic [31:0]     res;
    logic [1:0]      off;
    logic            resp;
    logic [31:0]     rdata;
    logic            e_we;
    logic [4:0]      e_rd;
    logic [31:0]     e_wd;
    logic [2:0]      e_cnt;
  } vec_t;

  function automatic vec_t mkv(logic v, logic [4:0] rd, regfilemux_sel_t s, logic [31:0] res,
                               logic [1:0] off, logic resp, logic [31:0] rdata, logic e_we,
                               logic [4:0] e_rd, logic [31:0] e_wd, logic [2:0] e_cnt);
    vec_t r;
    r.v = v; r.rd = rd; r.sel = s; r.res = res; r.off = off; r.resp = resp;
    r.rdata = rdata; r.e_we = e_we; r.e_rd = e_rd; r.e_wd = e_wd; r.e_cnt = e_cnt;
    return r;
  endfunction

  vec_t tbl[15];

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_rd = '0; in_sel = '0; in_result = '0; in_offset = '0;
    dmem_resp_valid = 1'b0; dmem_rdata = '0;
    model_reset();

    tbl[0]  = mkv(1'b1, 5'd5,  alu_out, 32'h1234, 2'd0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd1);
    tbl[1]  = mkv(1'b0, 5'd0,  alu_out, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1, 5'd5, 32'h1234, 3'd0);
    tbl[2]  = mkv(1'b1, 5'd3,  lb, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd1);
    tbl[3]  = mkv(1'b0, 5'd0,  alu_out, 32'h0, 2'd0, 1'b1, 32'h0080_0000,
                  1'b1, 5'd3, 32'hFFFF_FF80, 3'd0);
    tbl[4]  = mkv(1'b1, 5'd3,  lbu, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd1);
    tbl[5]  = mkv(1'b0, 5'd0,  alu_out, 32'h0, 2'd0, 1'b1, 32'h0080_0000,
                  1'b1, 5'd3, 32'h0000_0080, 3'd0);
    tbl[6]  = mkv(1'b1, 5'd0,  alu_out, 32'h55, 2'd0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd1);
    tbl[7]  = mkv(1'b1, 5'd7,  lhu, 32'h0, 2'd3, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd1);
`ifdef WB_MISALIGN_CHECK_EN
    tbl[8]  = mkv(1'b0, 5'd0,  alu_out, 32'h0, 2'd0, 1'b1, 32'hAB00_0000,
                  1'b0, 5'd0, 32'h0, 3'd0);
`else
    tbl[8]  = mkv(1'b0, 5'd0,  alu_out, 32'h0, 2'd0, 1'b1, 32'hAB00_0000,
                  1'b1, 5'd7, 32'h0000_00AB, 3'd0);
`endif
    tbl[9]  = mkv(1'b1, 5'd9,  lh, 32'h0, 2'd1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd1);
    tbl[10] = mkv(1'b0, 5'd0,  alu_out, 32'h0, 2'd0, 1'b1, 32'h00FF_8000,
                  1'b1, 5'd9, 32'hFFFF_FF80, 3'd0);
    tbl[11] = mkv(1'b1, 5'd10, lw, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd1);
    tbl[12] = mkv(1'b0, 5'd0,  alu_out, 32'h0, 2'd0, 1'b1, 32'hDEAD_BEEF,
                  1'b1, 5'd10, 32'hDEAD_BEEF, 3'd0);
    tbl[13] = mkv(1'b1, 5'd1,  u_imm, 32'hABCD_E000, 2'd0, 1'b0, 32'h0,
                  1'b0, 5'd0, 32'h0, 3'd1);
    tbl[14] = mkv(1'b0, 5'd0,  alu_out, 32'h0, 2'd0, 1'b0, 32'h0,
                  1'b1, 5'd1, 32'hABCD_E000, 3'd0);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].v, tbl[i].rd, tbl[i].sel, tbl[i].res, tbl[i].off, tbl[i].resp,
            tbl[i].rdata);
      chk($sformatf("tbl%0d_we", i), 32'(rf_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      if (tbl[i].e_we) begin
        chk($sformatf("tbl%0d_rd", i), 32'(rf_rd), 32'(tbl[i].e_rd));
        chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].e_wd);
      end
    end

    // Full queue: retire and attempted push in the same cycle must not push.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 5'(i + 2), lw, 32'h0, 2'd0, 1'b0, 32'h0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'(DEPTH));
    cycle(1'b1, 5'd9, alu_out, 32'h999, 2'd0, 1'b1, 32'h1111_1111);
    chk("full_retire_count", 32'(count), 32'(DEPTH - 1));
    chk("full_retire_rd", 32'(rf_rd), 32'd2);
    for (int i = 0; i < DEPTH - 1; i++)
      cycle(1'b0, 5'd0, alu_out, 32'h0, 2'd0, 1'b1, 32'h2222_0000 + 32'(i));
    idle();
    chk("full_drained", 32'(count), 32'd0);

    // Stray response on empty queue sets a sticky error and writes nothing.
    do_reset();
    cycle(1'b0, 5'd0, alu_out, 32'h0, 2'd0, 1'b1, 32'hFFFF_FFFF);
    chk("stray_err", 32'(resp_err), 32'd1);
    chk("stray_no_we", 32'(rf_we), 32'd0);
    repeat (3) idle();
    chk("stray_sticky", 32'(resp_err), 32'd1);

    // Stray response against a non-load head: head still retires.
    do_reset();
    cycle(1'b1, 5'd4, pc_plus4, 32'h0000_0104, 2'd0, 1'b0, 32'h0);
    cycle(1'b0, 5'd0, alu_out, 32'h0, 2'd0, 1'b1, 32'h7777_7777);
    chk("nonload_resp_err", 32'(resp_err), 32'd1);
    chk("nonload_wdata", rf_wdata, 32'h0000_0104);

    // Asynchronous reset in the middle of a cycle with entries pending.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 5'(i + 1), lw, 32'h0, 2'd0, 1'b0, 32'h0);
    cycle(1'b0, 5'd0, alu_out, 32'h0, 2'd0, 1'b1, 32'hCAFE_F00D);
    chk("pre_arst_we", 32'(rf_we), 32'd1);
    chk("pre_arst_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_we", 32'(rf_we), 32'd0);
    chk("arst_wdata", rf_wdata, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 5'd0, alu_out, 32'h0, 2'd0, 1'b1, 32'h1234_5678);
    chk("post_arst_err", 32'(resp_err), 32'd1);

    // Random traffic against the reference model.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        cycle(1'($urandom_range(0, 99) < 60),
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              regfilemux_sel_t'($urandom_range(0, 8)),
              $urandom, 2'($urandom),
              1'($urandom_range(0, 99) < (blk == 0 ? 50 : 35)),
              $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
